// File: rtl/frame_store.sv
// frame_store: single-frame pixel memory serving the 3x3 convolution scanner.
// Loads a frame from a byte stream, answers scanner reads, captures scanner
// result writes into a separate bank, then streams the result bank out.
module frame_store #(
  parameter int DEPTH = 2500,
  parameter int AW    = 14,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          start,
  input  logic [AW-1:0] read_select,
  output logic [DW-1:0] read_data,
  input  logic [AW-1:0] ws,
  input  logic          we,
  input  logic [DW-1:0] wd,
  input  logic          sys_finish,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          frame_done
);

  localparam int            CW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);
  localparam logic [AW-1:0] DEPTH_A  = AW'(DEPTH);

  typedef enum logic [1:0] {LOAD, SCAN, DUMP} state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic [DW-1:0] r_image  [DEPTH];
  logic [DW-1:0] r_result [DEPTH];

  logic [CW-1:0] r_load_cnt;
  logic [CW-1:0] r_dump_cnt;
  logic          r_in_ready;
  logic          r_start;
  logic [DW-1:0] r_read_data;
  logic [DW-1:0] r_out_data;
  logic          r_out_valid;
  logic          r_out_last;
  logic          r_frame_done;

  logic          w_load_hs;
  logic          w_load_last;
  logic          w_scan;
  logic          w_rd_ok;
  logic          w_res_wr;
  logic          w_out_hs;
  logic          w_dump_last;
  logic [CW-1:0] w_rd_idx;

  assign w_load_hs   = (r_state == LOAD) && in_valid && r_in_ready;
  assign w_load_last = w_load_hs && (r_load_cnt == LAST_IDX);
  assign w_scan      = (r_state == SCAN);
  assign w_rd_ok     = (read_select < DEPTH_A);
  assign w_res_wr    = w_scan && we && (ws < DEPTH_A);
  assign w_out_hs    = (r_state == DUMP) && r_out_valid && out_ready;
  assign w_dump_last = w_out_hs && r_out_last;
  // Look one index ahead on a handshake so the RAM read lands in the output
  // register exactly when the next byte must be presented; on a stall the
  // same index is re-read, which keeps out_data stable.
  assign w_rd_idx    = w_out_hs ? (r_dump_cnt + CW'(1)) : r_dump_cnt;

  assign in_ready   = r_in_ready;
  assign start      = r_start;
  assign read_data  = r_read_data;
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;
  assign frame_done = r_frame_done;

  // Next-state selection for the LOAD -> SCAN -> DUMP frame cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      LOAD:    if (w_load_last) w_next_state = SCAN;
      SCAN:    if (sys_finish)  w_next_state = DUMP;
      DUMP:    if (w_dump_last) w_next_state = LOAD;
      default: w_next_state = LOAD;
    endcase
  end

  // Image bank write port, fed by the upstream pixel stream.
  always_ff @(posedge clk) begin
    if (w_load_hs) r_image[r_load_cnt] <= in_data;
  end

  // Result bank write port, fed by the scanner; out-of-range writes dropped.
  always_ff @(posedge clk) begin
    if (w_res_wr) r_result[ws[CW-1:0]] <= wd;
  end

  // State register, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= LOAD;
      r_load_cnt   <= '0;
      r_dump_cnt   <= '0;
      r_in_ready   <= 1'b0;
      r_start      <= 1'b0;
      r_read_data  <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_in_ready   <= (w_next_state == LOAD);
      r_start      <= (w_next_state == SCAN);
      r_frame_done <= w_dump_last;

      if (w_load_hs) begin
        r_load_cnt <= w_load_last ? '0 : (r_load_cnt + CW'(1));
      end

      if (w_scan) begin
        r_read_data <= w_rd_ok ? r_image[read_select[CW-1:0]] : '0;
      end

      if (r_state == DUMP) begin
        if (w_dump_last) begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_dump_cnt  <= '0;
        end else begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_result[w_rd_idx];
          r_out_last  <= (w_rd_idx == LAST_IDX);
          r_dump_cnt  <= w_rd_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_store.sv
// Directed testbench for frame_store with a 16-pixel frame.
module tb_frame_store;
  localparam int DEPTH = 16;
  localparam int AW    = 14;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          start;
  logic [AW-1:0] read_select;
  logic [DW-1:0] read_data;
  logic [AW-1:0] ws;
  logic          we;
  logic [DW-1:0] wd;
  logic          sys_finish;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          frame_done;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_res [DEPTH];

  frame_store #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .start(start),
    .read_select(read_select), .read_data(read_data),
    .ws(ws), .we(we), .wd(wd), .sys_finish(sys_finish),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_data = '0; in_valid = 1'b0; read_select = '0;
    ws = '0; we = 1'b0; wd = '0; sys_finish = 1'b0; out_ready = 1'b0;
    tick(); tick();
    total++; if (in_ready !== 1'b0)   begin bad++; $display("FAIL reset_in_ready got=%0h exp=0", in_ready); end
    total++; if (start !== 1'b0)      begin bad++; $display("FAIL reset_start got=%0h exp=0", start); end
    total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    total++; if (out_last !== 1'b0)   begin bad++; $display("FAIL reset_out_last got=%0h exp=0", out_last); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%0h exp=0", frame_done); end
    total++; if (read_data !== 8'h00) begin bad++; $display("FAIL reset_read_data got=%0h exp=0", read_data); end
    total++; if (out_data !== 8'h00)  begin bad++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
    rst = 1'b0;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_rise got=%0h exp=1", in_ready); end
  endtask

  task automatic test_load();
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_data = DW'(8'h10 + i);
      if (i == DEPTH - 1) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL load_ready_before_last got=%0h exp=1", in_ready); end
      end
      tick();
    end
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL load_ready_fall got=%0h exp=0", in_ready); end
    total++; if (start !== 1'b1)    begin bad++; $display("FAIL load_start_rise got=%0h exp=1", start); end
  endtask

  task automatic test_scan_read();
    int            rs [4];
    logic [DW-1:0] ex [4];
    rs = '{0, 5, 15, 20};
    ex = '{8'h10, 8'h15, 8'h1F, 8'h00};
    for (int i = 0; i < 4; i++) begin
      read_select = AW'(rs[i]);
      tick();
      total++;
      if (read_data !== ex[i]) begin
        bad++; $display("FAIL scan_read sel=%0d got=%0h exp=%0h", rs[i], read_data, ex[i]);
      end
    end
    read_select = '0;
    tick();
    total++; if (read_data !== 8'h10) begin bad++; $display("FAIL scan_read sel=0 got=%0h exp=10", read_data); end
  endtask

  task automatic test_result_write();
    we = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      ws = AW'(i); wd = DW'(8'h80 + i); exp_res[i] = DW'(8'h80 + i);
      tick();
    end
    ws = AW'(3);  wd = 8'hAA; tick();
    ws = AW'(16); wd = 8'hBB; tick();
    ws = AW'(15); wd = 8'hCC; sys_finish = 1'b1; tick();
    we = 1'b0; sys_finish = 1'b0;
    exp_res[3]  = 8'hAA;
    exp_res[15] = 8'hCC;
    total++; if (start !== 1'b0)     begin bad++; $display("FAIL finish_start_fall got=%0h exp=0", start); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dump_entry_valid got=%0h exp=0", out_valid); end
    read_select = AW'(5); out_ready = 1'b0;
    tick();
    total++; if (out_valid !== 1'b1)     begin bad++; $display("FAIL dump_first_valid got=%0h exp=1", out_valid); end
    total++; if (out_data !== exp_res[0]) begin bad++; $display("FAIL dump_first_data got=%0h exp=%0h", out_data, exp_res[0]); end
    total++; if (read_data !== 8'h10)    begin bad++; $display("FAIL read_data_hold got=%0h exp=10", read_data); end
  endtask

  task automatic test_dump_stall();
    int            n  = 0;
    int            fd = 0;
    logic          pre_v, pre_l, rdy;
    logic [DW-1:0] pre_d;
    for (int c = 0; c < 100 && n < DEPTH; c++) begin
      pre_v = out_valid; pre_d = out_data; pre_l = out_last;
      rdy = ((c % 3) == 0);
      out_ready = rdy;
      if (pre_v && rdy) begin
        total++;
        if (out_data !== exp_res[n]) begin bad++; $display("FAIL dump_data idx=%0d got=%0h exp=%0h", n, out_data, exp_res[n]); end
        total++;
        if (out_last !== (n == DEPTH - 1)) begin bad++; $display("FAIL dump_last idx=%0d got=%0h exp=%0h", n, out_last, (n == DEPTH - 1)); end
        n++;
      end
      tick();
      if (pre_v && !rdy) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== pre_d || out_last !== pre_l) begin
          bad++; $display("FAIL dump_stall_hold got=%0h/%0h/%0h exp=1/%0h/%0h", out_valid, out_data, out_last, pre_d, pre_l);
        end
      end
      if (frame_done === 1'b1) fd++;
    end
    out_ready = 1'b0;
    total++; if (n != DEPTH)          begin bad++; $display("FAIL dump_hs_count got=%0d exp=%0d", n, DEPTH); end
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL dump_frame_done got=%0h exp=1", frame_done); end
    total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL dump_valid_drop got=%0h exp=0", out_valid); end
    tick();
    if (frame_done === 1'b1) fd++;
    total++; if (fd != 1)             begin bad++; $display("FAIL dump_frame_done_pulses got=%0d exp=1", fd); end
    total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL dump_rearm_in_ready got=%0h exp=1", in_ready); end
  endtask

  task automatic test_reset_mid_load();
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = DW'(8'h30 + i);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1; tick();
    rst = 1'b0; tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midload_in_ready got=%0h exp=1", in_ready); end
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_data = DW'(8'h40 + i);
      tick();
    end
    in_valid = 1'b0;
    total++; if (start !== 1'b1) begin bad++; $display("FAIL midload_start got=%0h exp=1", start); end
    read_select = AW'(0);  tick();
    total++; if (read_data !== 8'h40) begin bad++; $display("FAIL midload_img0 got=%0h exp=40", read_data); end
    read_select = AW'(15); tick();
    total++; if (read_data !== 8'h4F) begin bad++; $display("FAIL midload_img15 got=%0h exp=4f", read_data); end
    read_select = AW'(7);  tick();
    total++; if (read_data !== 8'h47) begin bad++; $display("FAIL midload_img7 got=%0h exp=47", read_data); end
  endtask

  task automatic test_reset_mid_dump();
    we = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      ws = AW'(i); wd = DW'(8'h60 + i);
      tick();
    end
    we = 1'b0;
    sys_finish = 1'b1; tick();
    sys_finish = 1'b0;
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== DW'(8'h60 + i)) begin
        bad++; $display("FAIL stream_byte idx=%0d got=%0h/%0h exp=1/%0h", i, out_valid, out_data, 8'h60 + i);
      end
      tick();
    end
    total++; if (out_data !== 8'h67 || out_last !== 1'b0) begin bad++; $display("FAIL stream_byte7 got=%0h/%0h exp=67/0", out_data, out_last); end
    rst = 1'b1; tick();
    total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL middump_valid got=%0h exp=0", out_valid); end
    total++; if (out_last !== 1'b0)   begin bad++; $display("FAIL middump_last got=%0h exp=0", out_last); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL middump_frame_done got=%0h exp=0", frame_done); end
    rst = 1'b0; tick();
    total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL middump_in_ready got=%0h exp=1", in_ready); end
    tick();
    total++; if (out_valid !== 1'b0 || frame_done !== 1'b0 || start !== 1'b0) begin
      bad++; $display("FAIL middump_idle got=%0h/%0h/%0h exp=0/0/0", out_valid, frame_done, start);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_scan_read();
    test_result_write();
    test_dump_stall();
    test_reset_mid_load();
    test_reset_mid_dump();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
